if_stage_pipe: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Owns the PC and produces the IF/ID register contents that ID and the hazard detection unit read.
- Consumes PCWrite and IF_ID_Write from the hazard detection unit, and branch redirect/flush from the ID-stage branch logic.
- Drives the instruction-memory address; instruction memory read is combinational and external.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pc_reg.sv | 39 +++
 rtl/if_stage_pipe.sv | 84 ++++++++
 tb/tb_if_stage_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants for the IF stage and the pipeline registers after it
package pipe_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  localparam int                 PC_INCR   = 4;

  // Low PC bits forced by this value when a redirect lands, keeping fetches word-aligned
  localparam logic [1:0] ALIGN_LSBS = 2'b00;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter register with write enable and sequential/redirect next-PC mux
module pc_reg
  import pipe_pkg::*;
#(
  parameter int                  PC_WIDTH = PC_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pcWrite,
  input  logic                branchTaken,
  input  logic [PC_WIDTH-1:0] branchTarget,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pcPlus4
);

  logic [PC_WIDTH-1:0] pcNext;
  logic [PC_WIDTH-1:0] alignedTarget;

  assign pcPlus4       = pc + PC_WIDTH'(PC_INCR);
  assign alignedTarget = {branchTarget[PC_WIDTH-1:$bits(ALIGN_LSBS)], ALIGN_LSBS};

  always_comb begin
    pcNext = pcPlus4;
    if (branchTaken) begin
      pcNext = alignedTarget;
    end
  end

  // Stall overrides any redirect: branch operands are not trustworthy while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (pcWrite) begin
      pc <= pcNext;
    end
  end

endmodule

// File: rtl/if_stage_pipe.sv
// rtl/if_stage_pipe.sv - instruction fetch stage and IF/ID register; IF_PERF_CNT_EN adds stall/flush counters
module if_stage_pipe
  import pipe_pkg::*;
#(
  parameter int                  PC_WIDTH    = PC_W,
  parameter int                  INSTR_WIDTH = INSTR_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   PCWrite,
  input  logic                   IF_ID_Write,
  input  logic                   Branch_Taken,
  input  logic [PC_WIDTH-1:0]    Branch_Target,
  output logic [PC_WIDTH-1:0]    Instr_Addr,
  input  logic [INSTR_WIDTH-1:0] Instr_In,
  output logic [INSTR_WIDTH-1:0] IF_ID_Instr,
  output logic [PC_WIDTH-1:0]    IF_ID_PCPlus4,
`ifdef IF_PERF_CNT_EN
  output logic                   IF_ID_Valid,
  output logic [31:0]            Stall_Cnt,
  output logic [31:0]            Flush_Cnt
`else
  output logic                   IF_ID_Valid
`endif
);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pcPlus4;

  pc_reg #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) uPcReg (
    .clk          (clk),
    .rst_n        (rst_n),
    .pcWrite      (PCWrite),
    .branchTaken  (Branch_Taken),
    .branchTarget (Branch_Target),
    .pc           (pc),
    .pcPlus4      (pcPlus4)
  );

  assign Instr_Addr = pc;

  // Hold beats flush, so a stalled ID keeps its instruction even if a redirect is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_Instr   <= INSTR_WIDTH'(NOP_INSTR);
      IF_ID_PCPlus4 <= '0;
      IF_ID_Valid   <= 1'b0;
    end else if (IF_ID_Write) begin
      if (Branch_Taken) begin
        IF_ID_Instr   <= INSTR_WIDTH'(NOP_INSTR);
        IF_ID_PCPlus4 <= '0;
        IF_ID_Valid   <= 1'b0;
      end else begin
        IF_ID_Instr   <= Instr_In;
        IF_ID_PCPlus4 <= pcPlus4;
        IF_ID_Valid   <= 1'b1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Stall_Cnt <= '0;
      Flush_Cnt <= '0;
    end else begin
      if (!PCWrite && (Stall_Cnt != '1)) begin
        Stall_Cnt <= Stall_Cnt + 32'd1;
      end
      if (IF_ID_Write && Branch_Taken && (Flush_Cnt != '1)) begin
        Flush_Cnt <= Flush_Cnt + 32'd1;
      end
    end
  end
`endif

  // Advancing the PC while IF/ID holds drops the fetched instruction
  illegalStallCombo: assert property (@(posedge clk) disable iff (!rst_n) !(PCWrite && !IF_ID_Write));

endmodule

// File: tb/tb_if_stage_pipe.sv
// tb/tb_if_stage_pipe.sv - randomized scoreboard bench for if_stage_pipe against a fetch-rule model
module tb_if_stage_pipe;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic        valid;
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PCWrite = 1'b1;
  logic        IF_ID_Write = 1'b1;
  logic        Branch_Taken = 1'b0;
  logic [31:0] Branch_Target = '0;
  logic [31:0] Instr_Addr;
  logic [31:0] Instr_In;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] Stall_Cnt;
  logic [31:0] Flush_Cnt;
`endif

  int   nTests = 0;
  int   nFail  = 0;
  int   nPops  = 0;
  exp_t sbQ[$];

  // Reference model state: architectural view of the fetch stage
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mPcPlus4;
  logic        mValid;
  int unsigned mStalls;
  int unsigned mFlushes;

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2008_0005;
  endfunction

  assign Instr_In = memWord(Instr_Addr);

  if_stage_pipe dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .PCWrite       (PCWrite),
    .IF_ID_Write   (IF_ID_Write),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .Instr_Addr    (Instr_Addr),
    .Instr_In      (Instr_In),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_PCPlus4 (IF_ID_PCPlus4),
`ifdef IF_PERF_CNT_EN
    .IF_ID_Valid   (IF_ID_Valid),
    .Stall_Cnt     (Stall_Cnt),
    .Flush_Cnt     (Flush_Cnt)
`else
    .IF_ID_Valid   (IF_ID_Valid)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mPc      = 32'h0;
    mInstr   = 32'h0;
    mPcPlus4 = 32'h0;
    mValid   = 1'b0;
    mStalls  = 0;
    mFlushes = 0;
  endtask

  task automatic checkResetState(input string tag);
    chk({tag, "_addr"},  Instr_Addr, 32'h0);
    chk({tag, "_instr"}, IF_ID_Instr, 32'h0);
    chk({tag, "_pcp4"},  IF_ID_PCPlus4, 32'h0);
    chk({tag, "_valid"}, {31'h0, IF_ID_Valid}, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk({tag, "_stallcnt"}, Stall_Cnt, 32'h0);
    chk({tag, "_flushcnt"}, Flush_Cnt, 32'h0);
`endif
  endtask

  // Drive one cycle of hazard/branch inputs, advance the model, and queue its expectation
  task automatic step(input logic pcw, input logic ifw, input logic bt, input logic [31:0] tgt);
    exp_t e;
    PCWrite       = pcw;
    IF_ID_Write   = ifw;
    Branch_Taken  = bt;
    Branch_Target = tgt;
    if (ifw) begin
      if (bt) begin
        mInstr = 32'h0; mPcPlus4 = 32'h0; mValid = 1'b0;
      end else begin
        mInstr = memWord(mPc); mPcPlus4 = mPc + 32'd4; mValid = 1'b1;
      end
    end
    if (!pcw) mStalls++;
    if (ifw && bt) mFlushes++;
    if (pcw) mPc = bt ? (tgt & 32'hFFFF_FFFC) : (mPc + 32'd4);
    e.addr = mPc; e.instr = mInstr; e.pcPlus4 = mPcPlus4; e.valid = mValid;
    e.stallCnt = mStalls; e.flushCnt = mFlushes;
    sbQ.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sbQ.size() > 0) begin
        e = sbQ.pop_front();
        nPops++;
        chk("instr_addr", Instr_Addr, e.addr);
        chk("ifid_instr", IF_ID_Instr, e.instr);
        chk("ifid_pcplus4", IF_ID_PCPlus4, e.pcPlus4);
        chk("ifid_valid", {31'h0, IF_ID_Valid}, {31'h0, e.valid});
`ifdef IF_PERF_CNT_EN
        chk("stall_cnt", Stall_Cnt, e.stallCnt);
        chk("flush_cnt", Flush_Cnt, e.flushCnt);
`endif
      end
    end
  end

  initial begin : stimulus
    int r;
    logic pcw, ifw, bt;
    modelReset();
    #2;
    checkResetState("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch up to PC=0x10, then a two-cycle load-use stall
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    // Taken branch with its one bubble
    step(1'b1, 1'b1, 1'b1, 32'h40);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    // Stall masks a branch; then misaligned target is forced aligned
    step(1'b0, 1'b0, 1'b1, 32'h80);
    step(1'b1, 1'b1, 1'b1, 32'h43);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    // Wrap past the top of the address space
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Asynchronous reset arriving mid-stall, away from any clock edge
    step(1'b0, 1'b0, 1'b1, 32'h100);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkResetState("async_rst");
    @(negedge clk);
    checkResetState("rst_held");
    chk("sb_empty_at_reset", sbQ.size(), 32'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        pcw = 1'b0; ifw = 1'b0;
      end else if (r < 3) begin
        pcw = 1'b0; ifw = 1'b1;
      end else begin
        pcw = 1'b1; ifw = 1'b1;
      end
      bt = ($urandom_range(0, 3) == 0);
      step(pcw, ifw, bt, $urandom);
    end

    PCWrite = 1'b0;
    IF_ID_Write = 1'b0;
    Branch_Taken = 1'b0;
    @(negedge clk);
    chk("sb_drained", sbQ.size(), 32'h0);
    chk("sb_pops", nPops, 32'd417);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
